// File: rtl/divider_pkg.sv
// divider_pkg: shared controller state type and default widths for the tick divider
package divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} ctrl_state_t;
  localparam int DIV_W_DEFAULT = 8;
endpackage

// File: rtl/tick_counter.sv
// tick_counter: period counter that wraps at div-1 and flags the last count of a period
module tick_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] count,
  output logic             last
);
  assign last = count == div - DIV_W'(1);
  // count up while enabled, wrap to 0 at the end of each period, hold at 0 when cleared
  always_ff @(posedge clk)
    count <= (reset || clr) ? '0 : !en ? count : last ? '0 : count + DIV_W'(1);
endmodule

// File: rtl/tick_divider_ctrl.sv
// tick_divider_ctrl: run/stop controller for a divide-by-N tick with glitch-free divisor updates
module tick_divider_ctrl
  import divider_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEFAULT,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic             tick,
  output logic             running,
  output logic             pending,
  output logic [DIV_W-1:0] cur_div
);
  ctrl_state_t      state, state_n;
  logic [DIV_W-1:0] count, pend_div;
  logic             last, xfer, apply, go;
  assign go        = start && !stop;
  assign cfg_ready = !pending;
  assign xfer      = cfg_valid && cfg_ready;
  assign apply     = pending && (state == IDLE || last);
  assign tick      = state == RUN && count == '0;
  assign running   = state != IDLE;
  tick_counter #(.DIV_W(DIV_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .div  (cur_div),
    .count(count),
    .last (last)
  );
  // next state: stop beats start; a restart while stopping keeps the current phase
  always_comb
    state_n = state == IDLE ? (go ? RUN : IDLE) :
              state == RUN  ? (stop ? STOPPING : RUN) :
              go ? RUN : last ? IDLE : STOPPING;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  // config slot: latch nonzero divisors, swap them in only on a period boundary
  always_ff @(posedge clk)
    if (reset) begin
      cur_div  <= DIV_W'(DEFAULT_DIV);
      pend_div <= '0;
      pending  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= xfer && cfg_div == '0;
      if (apply) begin
        cur_div <= pend_div;
        pending <= 1'b0;
      end else if (xfer && cfg_div != '0) begin
        pend_div <= cfg_div;
        pending  <= 1'b1;
      end
    end
endmodule

// File: tb/tb_tick_divider_ctrl.sv
// tb_tick_divider_ctrl: vector table, hand sequences and randomized run against a reference model
module tb_tick_divider_ctrl;
  localparam int W = 8;
  typedef struct {
    logic rst, st, sp, cv;
    logic [W-1:0] cd;
    logic t, r, p, e;
    logic [W-1:0] cur;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic cfg_ready, cfg_err, tick, running, pending;
  logic [W-1:0] cur_div;
  int checks = 0, failures = 0;
  int m_mode = 0, m_ph = 0, m_div = 3, m_pdiv = 0;
  bit m_pv = 0, m_err = 0;
  vec_t v[$];
  tick_divider_ctrl #(.DIV_W(W), .DEFAULT_DIV(3)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_div(cfg_div), .cfg_err(cfg_err),
    .tick(tick), .running(running), .pending(pending), .cur_div(cur_div)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(int rst, int st, int sp, int cv, int cd, int t, int r, int p, int e, int cur);
    vec_t x;
    x.rst = rst[0]; x.st = st[0]; x.sp = sp[0]; x.cv = cv[0]; x.cd = W'(cd);
    x.t = t[0]; x.r = r[0]; x.p = p[0]; x.e = e[0]; x.cur = W'(cur);
    return x;
  endfunction
  task automatic check(string name, logic [12:0] act, logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {tick,run,pend,rdy,err,div}=%b_%h expected %b_%h", name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask
  // spec-level model: mode 0 idle / 1 run / 2 stopping, phase counts through the period
  task automatic model_step();
    bit last, apply, xfer;
    if (reset) begin
      m_mode = 0; m_ph = 0; m_div = 3; m_pv = 0; m_err = 0;
      return;
    end
    last  = m_ph == m_div - 1;
    apply = m_pv && (m_mode == 0 || last);
    xfer  = cfg_valid && !m_pv;
    m_err = xfer && cfg_div == 0;
    m_ph  = (m_mode == 0 || last) ? 0 : m_ph + 1;
    case (m_mode)
      0: if (start && !stop) m_mode = 1;
      1: if (stop) m_mode = 2;
      default: if (start && !stop) m_mode = 1; else if (last) m_mode = 0;
    endcase
    if (apply) begin
      m_div = m_pdiv; m_pv = 0;
    end else if (xfer && cfg_div != 0) begin
      m_pdiv = int'(cfg_div); m_pv = 1;
    end
  endtask
  function automatic logic [12:0] dut_out();
    return {tick, running, pending, cfg_ready, cfg_err, cur_div};
  endfunction
  task automatic cyc(string name);
    @(posedge clk);
    model_step();
    #1;
    check(name, dut_out(), {m_mode == 1 && m_ph == 0, m_mode != 0, m_pv, !m_pv, m_err, W'(m_div)});
  endtask
  initial begin
    v.push_back(mk(1,0,0,0,0, 0,0,0,0,3));
    v.push_back(mk(0,1,0,0,0, 1,1,0,0,3));
    v.push_back(mk(0,0,0,0,0, 0,1,0,0,3));
    v.push_back(mk(0,0,0,0,0, 0,1,0,0,3));
    v.push_back(mk(0,0,0,0,0, 1,1,0,0,3));
    v.push_back(mk(0,0,0,0,0, 0,1,0,0,3));
    v.push_back(mk(0,0,0,1,5, 0,1,1,0,3));
    v.push_back(mk(0,0,0,0,0, 1,1,0,0,5));
    for (int i = 0; i < 4; i++) v.push_back(mk(0,0,0,0,0, 0,1,0,0,5));
    v.push_back(mk(0,0,0,0,0, 1,1,0,0,5));
    v.push_back(mk(0,0,0,1,0, 0,1,0,1,5));
    v.push_back(mk(0,0,0,0,0, 0,1,0,0,5));
    v.push_back(mk(0,0,1,0,0, 0,1,0,0,5));
    v.push_back(mk(0,0,0,0,0, 0,1,0,0,5));
    v.push_back(mk(0,0,0,0,0, 0,0,0,0,5));
    v.push_back(mk(0,1,1,0,0, 0,0,0,0,5));
    v.push_back(mk(0,1,0,0,0, 1,1,0,0,5));
    v.push_back(mk(0,0,0,1,7, 0,1,1,0,5));
    v.push_back(mk(1,0,0,0,0, 0,0,0,0,3));
    v.push_back(mk(0,0,0,0,0, 0,0,0,0,3));
    v.push_back(mk(0,0,0,1,1, 0,0,1,0,3));
    v.push_back(mk(0,0,0,0,0, 0,0,0,0,1));
    v.push_back(mk(0,1,0,0,0, 1,1,0,0,1));
    v.push_back(mk(0,0,0,0,0, 1,1,0,0,1));
    v.push_back(mk(0,0,1,0,0, 0,1,0,0,1));
    v.push_back(mk(0,0,0,0,0, 0,0,0,0,1));
    foreach (v[i]) begin
      reset = v[i].rst; start = v[i].st; stop = v[i].sp; cfg_valid = v[i].cv; cfg_div = v[i].cd;
      cyc($sformatf("vec%0d_model", i));
      check($sformatf("vec%0d", i), dut_out(), {v[i].t, v[i].r, v[i].p, !v[i].p, v[i].e, v[i].cur});
    end
    start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b1; cfg_div = W'(6);
    cyc("hold_accept");
    check("hold_pending", dut_out(), {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W'(1)});
    cyc("hold_apply");
    cfg_valid = 1'b0;
    check("hold_applied", dut_out(), {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W'(6)});
    cyc("hold_idle");
    reset = 1'b1;
    cyc("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 7) == 0;
      stop  = $urandom_range(0, 9) == 0;
      if (!(cfg_valid && m_pv)) begin
        cfg_valid = $urandom_range(0, 3) == 0;
        cfg_div = $urandom_range(0, 7) == 0 ? '0 : W'($urandom_range(1, 6));
      end
      cyc($sformatf("rand%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
